// File: rtl/osd_text_sched.sv
// OSD text-buffer write scheduler: arbitrates two character writers and a full-buffer
// clear, emitting each write as a stretched char_valid pulse followed by a quiet gap.
module osd_text_sched #(
    parameter int unsigned COLS         = 50,
    parameter int unsigned ROWS         = 10,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clr_req_i,
    output logic        clr_busy_o,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [15:0] req_x_i,
    input  logic [15:0] req_y_i,
    input  logic [13:0] req_char_i,
    output logic [7:0]  char_x_o,
    output logic [7:0]  char_y_o,
    output logic [6:0]  char_o,
    output logic        char_valid_o,
    output logic        drop_o,
    output logic        busy_o
);

    localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [6:0]  SPACE   = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_grant_q;
    logic             clr_pend_q;
    logic             clearing_q;
    logic             clr_busy_q;
    logic             char_valid_q;
    logic             drop_q;
    logic             busy_q;
    logic [7:0]       char_x_q;
    logic [7:0]       char_y_q;
    logic [6:0]       char_q;

    logic [1:0]       ready_c;
    logic             grant_idx;
    logic             xfer;
    logic [7:0]       sel_x;
    logic [7:0]       sel_y;
    logic [6:0]       sel_char;
    logic             in_range;
    logic             last_cell;

    // Round-robin grant; only offered while idle with no clear waiting
    always_comb begin
        ready_c = 2'b00;
        if (state_q == ST_IDLE && !clr_pend_q && !reset_i) begin
            if (&req_valid_i) begin
                ready_c = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                ready_c = req_valid_i;
            end
        end
    end

    assign grant_idx = ready_c[1];
    assign xfer      = |(req_valid_i & ready_c);
    assign sel_x     = grant_idx ? req_x_i[15:8]    : req_x_i[7:0];
    assign sel_y     = grant_idx ? req_y_i[15:8]    : req_y_i[7:0];
    assign sel_char  = grant_idx ? req_char_i[13:7] : req_char_i[6:0];
    assign in_range  = (sel_x < 8'(COLS)) && (sel_y < 8'(ROWS));
    assign last_cell = (char_x_q == 8'(COLS - 1)) && (char_y_q == 8'(ROWS - 1));

    // Write data is deliberately left out of reset so an aborted pulse ends on stable data
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            clr_pend_q   <= 1'b0;
            clearing_q   <= 1'b0;
            clr_busy_q   <= 1'b0;
            char_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (clr_req_i && !clr_busy_q) begin
                clr_pend_q <= 1'b1;
                clr_busy_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clr_pend_q) begin
                        clr_pend_q   <= 1'b0;
                        clearing_q   <= 1'b1;
                        char_x_q     <= '0;
                        char_y_q     <= '0;
                        char_q       <= SPACE;
                        cnt_q        <= '0;
                        char_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_PULSE;
                    end else if (xfer) begin
                        last_grant_q <= grant_idx;
                        if (in_range) begin
                            char_x_q     <= sel_x;
                            char_y_q     <= sel_y;
                            char_q       <= sel_char;
                            cnt_q        <= '0;
                            char_valid_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= ST_PULSE;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                        cnt_q        <= '0;
                        char_valid_q <= 1'b0;
                        state_q      <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_q <= '0;
                        if (clearing_q && !last_cell) begin
                            // Row-major walk straight into the next cell's pulse
                            if (char_x_q == 8'(COLS - 1)) begin
                                char_x_q <= '0;
                                char_y_q <= char_y_q + 8'd1;
                            end else begin
                                char_x_q <= char_x_q + 8'd1;
                            end
                            char_valid_q <= 1'b1;
                            state_q      <= ST_PULSE;
                        end else begin
                            if (clearing_q) begin
                                clr_busy_q <= 1'b0;
                            end
                            clearing_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    char_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_c;
    assign clr_busy_o   = clr_busy_q;
    assign char_x_o     = char_x_q;
    assign char_y_o     = char_y_q;
    assign char_o       = char_q;
    assign char_valid_o = char_valid_q;
    assign drop_o       = drop_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_osd_text_sched.sv
// Scoreboard bench for osd_text_sched: stimulus pushes expected writes/drops,
// a negedge monitor pops them as pulses and drop strobes appear.
module tb_osd_text_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr_req = 1'b0;
    logic        clr_busy_o;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready_o;
    logic [15:0] req_x = '0;
    logic [15:0] req_y = '0;
    logic [13:0] req_char = '0;
    logic [7:0]  char_x_o;
    logic [7:0]  char_y_o;
    logic [6:0]  char_o;
    logic        char_valid_o;
    logic        drop_o;
    logic        busy_o;

    osd_text_sched dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .clr_req_i   (clr_req),
        .clr_busy_o  (clr_busy_o),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_x_i     (req_x),
        .req_y_i     (req_y),
        .req_char_i  (req_char),
        .char_x_o    (char_x_o),
        .char_y_o    (char_y_o),
        .char_o      (char_o),
        .char_valid_o(char_valid_o),
        .drop_o      (drop_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_drop;
        logic [7:0] x;
        logic [7:0] y;
        logic [6:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_pulse(input logic [7:0] x, input logic [7:0] y, input logic [6:0] c);
        exp_t e;
        e.is_drop = 1'b0; e.x = x; e.y = y; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic push_drop();
        exp_t e;
        e.is_drop = 1'b1; e.x = '0; e.y = '0; e.c = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        for (int yy = 0; yy < 10; yy++)
            for (int xx = 0; xx < 50; xx++)
                push_pulse(8'(xx), 8'(yy), 7'h20);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_o !== 1'b0 || clr_busy_o !== 1'b0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) fail("idle_timeout");
    endtask

    // Two reset cycles with the given requests held; checks reset-state outputs
    task automatic do_reset(input logic [1:0] hold_valid);
        tick();
        reset = 1'b1;
        req_valid = hold_valid;
        clr_req = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rst_char_valid", 32'(char_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        tick();
        reset = 1'b0;
    endtask

    // Monitor: each char_valid rise or drop strobe consumes one expected entry
    logic prev_cv = 1'b0;
    int   plen = 0;
    bit   aborted = 1'b0;
    always @(negedge clk) begin
        if (char_valid_o === 1'b1) begin
            if (!prev_cv) begin
                plen = 1;
                aborted = 1'b0;
                if (exp_q.size() == 0) begin
                    fail("unexpected_pulse");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind", 32'(e.is_drop), 32'd0);
                    chk("pulse_data", {9'd0, char_x_o, char_y_o, char_o}, {9'd0, e.x, e.y, e.c});
                end
            end else begin
                plen++;
            end
            if (reset === 1'b1) aborted = 1'b1;
        end else if (prev_cv && !aborted) begin
            chk("pulse_width", 32'(plen), 32'd4);
        end
        if (drop_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_drop");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("drop_kind", 32'(e.is_drop), 32'd1);
            end
        end
        prev_cv = (char_valid_o === 1'b1);
    end

    task automatic set_t2_data(input int i0, input int i1);
        req_x    = {8'(10 + i1), 8'(i0)};
        req_y    = {8'd5, 8'd0};
        req_char = {7'(7'h57 + 7'(i1)), 7'(7'h61 + 7'(i0))};
    endtask

    initial begin
        do_reset(2'b00);

        // Single write: timing and data stability over pulse and gap
        tick();
        req_valid = 2'b01; req_x = {8'd0, 8'd3}; req_y = {8'd0, 8'd2}; req_char = {7'd0, 7'h41};
        @(negedge clk);
        chk("t1_ready_T", 32'(req_ready_o), 32'h1);
        push_pulse(8'd3, 8'd2, 7'h41);
        tick();
        req_x = {8'd0, 8'd4}; req_char = {7'd0, 7'h42};
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                chk("t1_char_valid", 32'(char_valid_o), (k <= 4) ? 32'd1 : 32'd0);
                chk("t1_data", {9'd0, char_x_o, char_y_o, char_o}, {9'd0, 8'd3, 8'd2, 7'h41});
                chk("t1_ready_busy", 32'(req_ready_o), 32'h0);
            end else begin
                chk("t1_ready_T9", 32'(req_ready_o), 32'h1);
                push_pulse(8'd4, 8'd2, 7'h42);
            end
        end
        tick();
        req_valid = 2'b00;
        wait_idle();

        // Round robin with both held across reset; first grant is port 0
        set_t2_data(0, 0);
        do_reset(2'b11);
        begin
            int i0 = 0, i1 = 0, prev = 0, n;
            logic exp_port = 1'b0;
            for (int g = 0; g < 8; g++) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (req_ready_o === 2'b00 && n < 20);
                if (n >= 20) begin
                    fail("t2_grant_timeout");
                    break;
                end
                chk("t2_grant", 32'(req_ready_o), exp_port ? 32'h2 : 32'h1);
                if (g > 0) chk("t2_spacing", 32'(cyc - prev), 32'd9);
                prev = cyc;
                if (req_ready_o[1]) begin
                    push_pulse(8'(10 + i1), 8'd5, 7'(7'h57 + 7'(i1)));
                    i1++;
                end else begin
                    push_pulse(8'(i0), 8'd0, 7'(7'h61 + 7'(i0)));
                    i0++;
                end
                tick();
                set_t2_data(i0, i1);
                if (i0 == 4) req_valid[0] = 1'b0;
                if (i1 == 4) req_valid[1] = 1'b0;
                exp_port = ~exp_port;
            end
            req_valid = 2'b00;
        end
        wait_idle();

        // Out-of-range x is dropped, next request accepted the following cycle
        tick();
        req_valid = 2'b01; req_x = {8'd0, 8'd50}; req_y = {8'd0, 8'd0}; req_char = {7'd0, 7'h58};
        @(negedge clk);
        chk("t4_ready_oob", 32'(req_ready_o), 32'h1);
        push_drop();
        tick();
        req_x = {8'd0, 8'd5}; req_y = {8'd0, 8'd1}; req_char = {7'd0, 7'h51};
        @(negedge clk);
        chk("t4_drop", 32'(drop_o), 32'd1);
        chk("t4_no_pulse", 32'(char_valid_o), 32'd0);
        chk("t4_ready_next", 32'(req_ready_o), 32'h1);
        push_pulse(8'd5, 8'd1, 7'h51);
        tick();
        req_valid = 2'b00;
        wait_idle();
        tick();
        req_valid = 2'b10; req_x = {8'd0, 8'd0}; req_y = {8'd10, 8'd0}; req_char = {7'h59, 7'd0};
        @(negedge clk);
        chk("t4_ready_oob_y", 32'(req_ready_o), 32'h2);
        push_drop();
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t4_drop_y", 32'(drop_o), 32'd1);
        chk("t4_busy_y", 32'(busy_o), 32'd0);
        wait_idle();

        // Idle clear: 500 space writes, clr_busy length measured from the cycle after clr_req
        tick();
        clr_req = 1'b1;
        push_clear();
        tick();
        clr_req = 1'b0;
        begin
            int n = 0;
            while (n < 6000) begin
                @(negedge clk);
                if (clr_busy_o !== 1'b1) break;
                n++;
            end
            chk("t3_clear_len", 32'(n), 32'd4001);
        end
        wait_idle();

        // Clear coincident with a port-1 transfer; requests locked out for the whole clear
        tick();
        clr_req = 1'b1;
        req_valid = 2'b10; req_x = {8'd7, 8'd1}; req_y = {8'd3, 8'd1}; req_char = {7'h4d, 7'h6e};
        @(negedge clk);
        chk("t5_ready_p1", 32'(req_ready_o), 32'h2);
        push_pulse(8'd7, 8'd3, 7'h4d);
        push_clear();
        tick();
        clr_req = 1'b0;
        req_valid = 2'b11;
        begin
            int n = 0;
            bit leaked = 1'b0;
            while (n < 6000) begin
                @(negedge clk);
                if (clr_busy_o !== 1'b1) break;
                if (req_ready_o !== 2'b00) leaked = 1'b1;
                n++;
            end
            chk("t5_ready_locked", 32'(leaked), 32'd0);
            chk("t5_ready_after", 32'(req_ready_o), 32'h1);
            push_pulse(8'd1, 8'd1, 7'h6e);
        end
        tick();
        req_valid = 2'b00;
        wait_idle();

        // Reset in the second cycle of a pulse
        tick();
        req_valid = 2'b01; req_x = {8'd0, 8'd9}; req_y = {8'd0, 8'd4}; req_char = {7'd0, 7'h52};
        @(negedge clk);
        chk("t6_ready", 32'(req_ready_o), 32'h1);
        push_pulse(8'd9, 8'd4, 7'h52);
        tick();
        req_valid = 2'b00;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_cv_before", 32'(char_valid_o), 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_cv_cut", 32'(char_valid_o), 32'd0);
        chk("t6_data_held", {9'd0, char_x_o, char_y_o, char_o}, {9'd0, 8'd9, 8'd4, 7'h52});
        chk("t6_busy", 32'(busy_o), 32'd0);
        repeat (12) tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
